// File: rtl/four_way_rr_arbiter_pkg.sv
// Shared arbiter definitions: requester count, index width, FSM state encoding.
package four_way_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/four_way_rr_arbiter_grant_encoder.sv
// One-hot to binary grant index for the datapath select lines; zero maps to index 0.
module grant_encoder
  import four_way_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  assign idx = {onehot[2] | onehot[3], onehot[1] | onehot[3]};

endmodule

// File: rtl/four_way_rr_arbiter.sv
// Four-requester round-robin arbiter with hold limit and a one-cycle turnaround gap.
module four_way_rr_arbiter
  import four_way_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 15  // legal 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rel;

  // First set request scanning ptr, ptr+1, ... ; descending loop lets the
  // smallest offset overwrite the others.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] k;
    rr_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) begin
        rr_pick    = '0;
        rr_pick[k] = 1'b1;
      end
    end
  endfunction

  grant_encoder u_enc (
    .onehot (grant_q),
    .idx    (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d = rr_pick(req, ptr_q);
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Coincident release causes collapse into one release; ptr moves once.
        rel = done || !req[grant_idx] || (cnt_q == CNT_W'(MAX_HOLD - 1));
        if (rel) begin
          grant_d = '0;
          ptr_d   = grant_idx + 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;

endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// Directed scoreboard bench: stimulus queues expected grants, a negedge monitor checks each completed grant.
module tb_four_way_rr_arbiter;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    int         len;
    int         gap;   // zero-grant cycles before this grant; -1 = don't care
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [3:0] prev_g  = '0;
  logic [3:0] cur_g   = '0;
  logic [1:0] cur_idx = '0;
  logic       cur_vld = 1'b0;
  int         cur_len = 0;
  int         cur_gap = 0;
  int         zeros   = 0;

  four_way_rr_arbiter #(.MAX_HOLD(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] idx, input int len, input int gap);
    exp_t e;
    e.g = g; e.idx = idx; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic close_grant();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_grant: got %b expected none at %0t", cur_g, $time);
    end else begin
      e = exp_q.pop_front();
      chk("grant_vec", int'(cur_g), int'(e.g));
      chk("grant_idx", int'(cur_idx), int'(e.idx));
      chk("grant_len", cur_len, e.len);
      chk("grant_valid", int'(cur_vld), 1);
      if (e.gap >= 0) chk("gap_len", cur_gap, e.gap);
    end
  endtask

  // Monitor: grants are tracked as runs of identical nonzero grant vectors.
  always @(negedge clk) begin
    chk("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    if (grant !== prev_g) begin
      if (prev_g != 4'b0000) close_grant();
      if (grant != 4'b0000) begin
        cur_g   = grant;
        cur_idx = grant_idx;
        cur_vld = grant_valid;
        cur_len = 1;
        cur_gap = zeros;
      end
      zeros = (grant == 4'b0000) ? 1 : 0;
    end else if (grant != 4'b0000) begin
      cur_len++;
    end else begin
      zeros++;
    end
    prev_g = grant;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Current grant is visible now; keep it n cycles total, ending with done.
  task automatic serve(input int n, input logic [3:0] nxt);
    cyc(n - 1);
    done = 1'b1;
    req  = nxt;
    cyc(1);
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    cyc(3);
    chk("rst_grant", int'(grant), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_valid", int'(grant_valid), 0);
    rst_n = 1'b1;

    // Single request, released by done; leaves ptr at 3.
    req = 4'b0100;
    push(4'b0100, 2'd2, 3, -1);
    cyc(1);
    serve(3, 4'b0110);

    // ptr=3 with req 0110 wraps to requester 1, skipping 2.
    push(4'b0010, 2'd1, 2, 2);
    cyc(2);
    serve(2, 4'b1000);

    // Park ptr at 0 via requester 3.
    push(4'b1000, 2'd3, 1, 2);
    cyc(2);
    serve(1, 4'b1111);

    // Rotation with all requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      push(4'(1 << (i % 4)), 2'(i % 4), i + 1, 2);
      cyc(2);
      serve(i + 1, (i == 4) ? 4'b1000 : 4'b1111);
    end
    push(4'b1000, 2'd3, 1, 2);
    cyc(2);
    serve(1, 4'b0011);

    // Timeout on requester 0, then requester 1 released by dropping its request.
    push(4'b0001, 2'd0, 15, 2);
    push(4'b0010, 2'd1, 4, 2);
    cyc(2);
    cyc(15);
    cyc(2);
    cyc(3);
    req = 4'b0100;
    cyc(1);

    // done, request drop and hold limit all on the same edge.
    push(4'b0100, 2'd2, 15, 2);
    cyc(2);
    cyc(14);
    done = 1'b1;
    req  = 4'b1011;
    cyc(1);
    done = 1'b0;
    req  = 4'b1111;

    // Single ptr step leaves ptr=3 -> requester 3; then async reset mid-grant.
    push(4'b1000, 2'd3, 1, 2);
    cyc(2);
    cyc(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", int'(grant), 0);
    chk("async_rst_valid", int'(grant_valid), 0);
    chk("async_rst_idx", int'(grant_idx), 0);
    req = 4'b1001;
    #3;
    rst_n = 1'b1;

    // ptr restored to 0 by reset.
    push(4'b0001, 2'd0, 2, -1);
    @(posedge clk);
    #1;
    serve(2, 4'b0000);

    cyc(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
